// File: rtl/ray_pixel_stream_merger.sv
// ray_pixel_stream_merger
//   Collects shaded pixels from N_LANES ray processors (lane i owns frame pixel
//   indices k with k mod N_LANES == i), buffers each lane in a small FIFO and
//   re-serialises them in raster order onto one valid/ready video stream.
//
// Ports
//   clk, reset_n        clock, synchronous active-low reset
//   image_width/height  frame dimensions, latched at the first pop of a frame
//   lane_valid/lane_rgb per-lane pixel push ({r,g,b}, r in the MSBs)
//   lane_ready          per-lane FIFO not full (registered state only)
//   ready_external      downstream ready
//   valid_data_out, r, g, b, last_x, sof   registered output pixel
//   frame_done          one-cycle pulse after the frame's last pixel is accepted
module ray_pixel_stream_merger #(
    parameter int N_LANES    = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int COLOR_W    = 8,
    parameter int DIM_W      = 13
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [DIM_W-1:0]               image_width,
    input  logic [DIM_W-1:0]               image_height,
    input  logic [N_LANES-1:0]             lane_valid,
    input  logic [N_LANES*3*COLOR_W-1:0]   lane_rgb,
    output logic [N_LANES-1:0]             lane_ready,
    input  logic                           ready_external,
    output logic                           valid_data_out,
    output logic [COLOR_W-1:0]             r,
    output logic [COLOR_W-1:0]             g,
    output logic [COLOR_W-1:0]             b,
    output logic                           last_x,
    output logic                           sof,
    output logic                           frame_done
);

    localparam int PIX_W  = 3 * COLOR_W;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int LANE_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} stateType;

    logic [PIX_W-1:0]   fifoMem   [N_LANES][FIFO_DEPTH];
    logic [PTR_W-1:0]   wrPtr     [N_LANES];
    logic [PTR_W-1:0]   rdPtr     [N_LANES];
    logic [CNT_W-1:0]   fifoCount [N_LANES];
    logic [N_LANES-1:0] fifoPush;
    logic [N_LANES-1:0] fifoPop;
    logic [N_LANES-1:0] fifoNonEmpty;

    stateType           state, stateNext;
    logic [LANE_W-1:0]  laneSel;
    logic [DIM_W-1:0]   x, y;
    logic [DIM_W-1:0]   widthLat, heightLat;
    logic [DIM_W-1:0]   xLast, yLast;
    logic [PIX_W-1:0]   headPix;
    logic               canLoad, acceptOut, frameEnd, popEn, frameDoneNext;

    // Lane-side handshake; ready depends only on registered occupancy, so a
    // full FIFO refuses a push even in a cycle where it is being popped.
    always_comb begin
        lane_ready   = '0;
        fifoPush     = '0;
        fifoPop      = '0;
        fifoNonEmpty = '0;
        for (int i = 0; i < N_LANES; i++) begin
            lane_ready[i]   = fifoCount[i] < CNT_W'(FIFO_DEPTH);
            fifoPush[i]     = lane_valid[i] && lane_ready[i];
            fifoPop[i]      = popEn && (laneSel == LANE_W'(i));
            fifoNonEmpty[i] = fifoCount[i] != '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < N_LANES; i++) begin
                wrPtr[i]     <= '0;
                rdPtr[i]     <= '0;
                fifoCount[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_LANES; i++) begin
                if (fifoPush[i]) wrPtr[i] <= wrPtr[i] + PTR_W'(1);
                if (fifoPop[i])  rdPtr[i] <= rdPtr[i] + PTR_W'(1);
                unique case ({fifoPush[i], fifoPop[i]})
                    2'b10:   fifoCount[i] <= fifoCount[i] + CNT_W'(1);
                    2'b01:   fifoCount[i] <= fifoCount[i] - CNT_W'(1);
                    default: fifoCount[i] <= fifoCount[i];
                endcase
            end
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_LANES; i++) begin
            if (fifoPush[i]) fifoMem[i][wrPtr[i]] <= lane_rgb[i*PIX_W +: PIX_W];
        end
    end

    assign headPix = fifoMem[laneSel][rdPtr[laneSel]];

    // In IDLE the dimensions are about to be latched, so the live inputs
    // define the first pixel's position flags.
    always_comb begin
        xLast     = (state == IDLE) ? image_width  - DIM_W'(1) : widthLat  - DIM_W'(1);
        yLast     = (state == IDLE) ? image_height - DIM_W'(1) : heightLat - DIM_W'(1);
        frameEnd  = (x == xLast) && (y == yLast);
        canLoad   = !valid_data_out || ready_external;
        acceptOut = valid_data_out && ready_external;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= stateNext;
    end

    always_comb begin
        stateNext     = state;
        popEn         = 1'b0;
        frameDoneNext = 1'b0;
        unique case (state)
            IDLE: begin
                if (image_width != '0 && image_height != '0 &&
                    fifoNonEmpty[laneSel] && canLoad) begin
                    popEn     = 1'b1;
                    stateNext = frameEnd ? DRAIN : STREAM;
                end
            end
            STREAM: begin
                if (fifoNonEmpty[laneSel] && canLoad) begin
                    popEn = 1'b1;
                    if (frameEnd) stateNext = DRAIN;
                end
            end
            DRAIN: begin
                // The output register holds the frame's final pixel here.
                if (acceptOut) begin
                    frameDoneNext = 1'b1;
                    stateNext     = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            laneSel        <= '0;
            x              <= '0;
            y              <= '0;
            widthLat       <= '0;
            heightLat      <= '0;
            valid_data_out <= 1'b0;
            r              <= '0;
            g              <= '0;
            b              <= '0;
            last_x         <= 1'b0;
            sof            <= 1'b0;
            frame_done     <= 1'b0;
        end else begin
            frame_done <= frameDoneNext;
            if (popEn) begin
                if (state == IDLE) begin
                    widthLat  <= image_width;
                    heightLat <= image_height;
                end
                valid_data_out <= 1'b1;
                {r, g, b}      <= headPix;
                last_x         <= (x == xLast);
                sof            <= (x == '0) && (y == '0);
                if (frameEnd) begin
                    // Lane indexing restarts every frame.
                    laneSel <= '0;
                    x       <= '0;
                    y       <= '0;
                end else begin
                    laneSel <= (laneSel == LANE_W'(N_LANES - 1)) ? '0 : laneSel + LANE_W'(1);
                    if (x == xLast) begin
                        x <= '0;
                        y <= y + DIM_W'(1);
                    end else begin
                        x <= x + DIM_W'(1);
                    end
                end
            end else if (acceptOut) begin
                valid_data_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ray_pixel_stream_merger.sv
// Scoreboard bench for ray_pixel_stream_merger: frames are split into per-lane
// queues, expected raster-order pixels are queued alongside, and every accepted
// output pixel is popped and compared.
module tb_ray_pixel_stream_merger;

    localparam int NL = 4;
    localparam int CW = 8;
    localparam int DW = 13;
    localparam int PW = 3 * CW;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [DW-1:0]     image_width, image_height;
    logic [NL-1:0]     lane_valid;
    logic [NL*PW-1:0]  lane_rgb;
    logic [NL-1:0]     lane_ready;
    logic              ready_external;
    logic              valid_data_out;
    logic [CW-1:0]     r, g, b;
    logic              last_x, sof, frame_done;

    always #5 clk = ~clk;

    ray_pixel_stream_merger #(
        .N_LANES(NL), .FIFO_DEPTH(4), .COLOR_W(CW), .DIM_W(DW)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .image_width(image_width), .image_height(image_height),
        .lane_valid(lane_valid), .lane_rgb(lane_rgb), .lane_ready(lane_ready),
        .ready_external(ready_external), .valid_data_out(valid_data_out),
        .r(r), .g(g), .b(b), .last_x(last_x), .sof(sof), .frame_done(frame_done)
    );

    typedef struct packed {
        logic [PW-1:0] pix;
        logic          lastX;
        logic          sof;
        logic          endFrame;
    } expPixType;

    logic [PW-1:0] laneQ [NL][$];
    expPixType     expQ[$];

    int            nCompared = 0;
    int            nMismatched = 0;
    int            acceptCount, doneCount, firstAcceptCyc, lastAcceptCyc;
    int            pushCount [NL];
    logic [NL-1:0] sawNotReady;
    int            holdLane;
    int            holdCycles;
    bit            toggleReady;
    logic          doneExpected;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] expVal);
        nCompared++;
        if (got !== expVal) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, expVal, $time);
        end
    endtask

    task automatic clearState();
        for (int i = 0; i < NL; i++) begin
            laneQ[i].delete();
            pushCount[i] = 0;
        end
        expQ.delete();
        acceptCount    = 0;
        doneCount      = 0;
        firstAcceptCyc = -1;
        lastAcceptCyc  = -1;
        sawNotReady    = '0;
        doneExpected   = 1'b0;
        holdLane       = -1;
        holdCycles     = 0;
        toggleReady    = 1'b0;
    endtask

    // Pixel k of a frame: r = k, g = frame tag, b = ~k.
    task automatic loadFrame(input int w, input int h, input int tag);
        logic [PW-1:0] p;
        expPixType     e;
        for (int k = 0; k < w * h; k++) begin
            p = {CW'(k), CW'(tag), ~CW'(k)};
            laneQ[k % NL].push_back(p);
            e.pix      = p;
            e.lastX    = ((k % w) == (w - 1));
            e.sof      = (k == 0);
            e.endFrame = (k == w * h - 1);
            expQ.push_back(e);
        end
    endtask

    task automatic runCycles(input int maxCyc, input bit untilEmpty, input int stopAfter);
        int            cyc;
        bit            allEmpty;
        logic [NL-1:0] pushed;
        logic          nextDone;
        logic          prevHeld;
        logic [PW+2:0] saved;
        expPixType     e;
        cyc      = 0;
        prevHeld = 1'b0;
        saved    = '0;
        forever begin
            allEmpty = 1'b1;
            for (int i = 0; i < NL; i++) if (laneQ[i].size() != 0) allEmpty = 1'b0;
            if (untilEmpty && allEmpty && expQ.size() == 0 && !doneExpected) break;
            if (stopAfter > 0 && acceptCount >= stopAfter) break;
            if (cyc >= maxCyc) begin
                if (untilEmpty) checkVal("drain_timeout", expQ.size(), 0);
                break;
            end

            for (int i = 0; i < NL; i++) begin
                lane_valid[i] = (laneQ[i].size() != 0) && !(holdLane == i && cyc < holdCycles);
                if (laneQ[i].size() != 0) lane_rgb[i*PW +: PW] = laneQ[i][0];
            end
            ready_external = toggleReady ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;

            checkVal("frame_done", frame_done, doneExpected);
            if (frame_done) doneCount++;
            if (prevHeld) checkVal("hold_stable", {valid_data_out, r, g, b, last_x, sof}, saved);

            nextDone = 1'b0;
            if (valid_data_out && ready_external) begin
                if (expQ.size() == 0) begin
                    checkVal("extra_output", valid_data_out, 0);
                end else begin
                    e = expQ.pop_front();
                    checkVal("pix_rgb", {r, g, b}, e.pix);
                    checkVal("last_x", last_x, e.lastX);
                    checkVal("sof", sof, e.sof);
                    nextDone = e.endFrame;
                    if (acceptCount == 0) firstAcceptCyc = cyc;
                    lastAcceptCyc = cyc;
                    acceptCount++;
                end
            end

            sawNotReady = sawNotReady | ~lane_ready;
            if (holdLane >= 0 && cyc == holdCycles - 1) begin
                checkVal("stall_ready", lane_ready, 4'b0100);
                checkVal("stall_count", acceptCount, 2);
            end

            prevHeld = valid_data_out && !ready_external;
            saved    = {valid_data_out, r, g, b, last_x, sof};
            pushed   = lane_valid & lane_ready;

            @(posedge clk);
            #1;
            for (int i = 0; i < NL; i++) begin
                if (pushed[i]) begin
                    void'(laneQ[i].pop_front());
                    pushCount[i]++;
                end
            end
            doneExpected = nextDone;
            cyc++;
        end
        lane_valid = '0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n        = 1'b0;
        lane_valid     = '0;
        lane_rgb       = '0;
        ready_external = 1'b0;
        image_width    = 8;
        image_height   = 2;
        clearState();
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        checkVal("rst_valid", valid_data_out, 0);
        checkVal("rst_ready", lane_ready, 4'hF);
        checkVal("rst_fields", {r, g, b, last_x, sof}, 0);
        checkVal("rst_done", frame_done, 0);

        // Continuous 8x2 frame, downstream always ready.
        clearState();
        image_width = 8; image_height = 2;
        loadFrame(8, 2, 1);
        runCycles(200, 1'b1, 0);
        checkVal("t1_latency", firstAcceptCyc, 2);
        checkVal("t1_no_gaps", lastAcceptCyc - firstAcceptCyc, 15);
        checkVal("t1_count", acceptCount, 16);
        checkVal("t1_done_cnt", doneCount, 1);

        // Back-pressure pattern 1,0,0,1 on an 8x4 frame.
        clearState();
        image_width = 8; image_height = 4;
        toggleReady = 1'b1;
        loadFrame(8, 4, 2);
        runCycles(400, 1'b1, 0);
        checkVal("t2_count", acceptCount, 32);
        checkVal("t2_lanes_full", sawNotReady, 4'hF);
        checkVal("t2_done_cnt", doneCount, 1);

        // Lane 2 withheld for 20 cycles.
        clearState();
        image_width = 8; image_height = 4;
        holdLane = 2; holdCycles = 20;
        loadFrame(8, 4, 3);
        runCycles(400, 1'b1, 0);
        checkVal("t3_count", acceptCount, 32);
        checkVal("t3_done_cnt", doneCount, 1);

        // Two back-to-back 5x3 frames.
        clearState();
        image_width = 5; image_height = 3;
        loadFrame(5, 3, 4);
        loadFrame(5, 3, 5);
        runCycles(400, 1'b1, 0);
        checkVal("t4_count", acceptCount, 30);
        checkVal("t4_done_cnt", doneCount, 2);

        // Reset mid-frame after 6 pixels, then a fresh 4x2 frame.
        clearState();
        image_width = 8; image_height = 2;
        loadFrame(8, 2, 6);
        runCycles(200, 1'b1, 6);
        checkVal("t5_pre_count", acceptCount, 6);
        reset_n    = 1'b0;
        lane_valid = '0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        checkVal("t5_valid", valid_data_out, 0);
        checkVal("t5_ready", lane_ready, 4'hF);
        checkVal("t5_done", frame_done, 0);
        clearState();
        image_width = 4; image_height = 2;
        loadFrame(4, 2, 7);
        runCycles(200, 1'b1, 0);
        checkVal("t5_count", acceptCount, 8);
        checkVal("t5_done_cnt", doneCount, 1);

        // Zero width: nothing may leave, FIFOs fill up.
        clearState();
        image_width = 0; image_height = 2;
        for (int i = 0; i < NL; i++)
            for (int k = 0; k < 6; k++) laneQ[i].push_back(PW'(i * 16 + k));
        runCycles(20, 1'b0, 0);
        for (int i = 0; i < NL; i++) checkVal("t6_pushes", pushCount[i], 4);
        checkVal("t6_ready", lane_ready, 4'h0);
        checkVal("t6_count", acceptCount, 0);
        checkVal("t6_done_cnt", doneCount, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/ray_pixel_stream_merger.md
Name: ray_pixel_stream_merger

Overview:
Multi-lane output stage for the ray tracing unit. It accepts shaded pixels from N_LANES parallel ray processors, where lane i owns frame pixel indices k with k mod N_LANES == i. It buffers each lane in a small FIFO and re-serialises the pixels in raster order into a single video stream with valid/ready, last_x (end of line) and sof (start of frame). This stage replaces the single-processor output path so that throughput scales with lane count.

Parameters:
N_LANES, 4, number of ray processor lanes (>=1)
FIFO_DEPTH, 4, entries per lane FIFO (power of 2, >=2)
COLOR_W, 8, bits per colour channel
DIM_W, 13, width of the image dimension inputs and x/y counters

Ports:
clk  input  1  system clock
reset_n  input  1  synchronous reset, active low
image_width  input  DIM_W  pixels per line; sampled at frame start
image_height  input  DIM_W  lines per frame; sampled at frame start
lane_valid  input  N_LANES  per-lane pixel valid
lane_rgb  input  N_LANES*3*COLOR_W  lane i occupies [i*3*COLOR_W +: 3*COLOR_W], packed {r,g,b} with r in the MSBs
lane_ready  output  N_LANES  per-lane FIFO not full
ready_external  input  1  downstream ready
valid_data_out  output  1  output pixel valid
r, g, b  output  COLOR_W each  output pixel colour
last_x  output  1  output pixel is the last pixel of its line
sof  output  1  output pixel is pixel (0,0) of the frame
frame_done  output  1  one-cycle pulse when the last pixel of a frame is accepted downstream

Behaviour:
- Reset (reset_n low at a clock edge):
  - All FIFOs are emptied; lane_sel, x and y are set to 0; FSM goes to IDLE.
  - All outputs are 0, except lane_ready, which is all-ones from the first cycle after reset is released.
  - Reset asserted mid-frame discards all buffered and in-flight pixels. No frame_done is generated.
- Lane push: occurs when lane_valid[i] && lane_ready[i].
  - lane_ready[i] = (count_i < FIFO_DEPTH), computed from registered state only. There is no same-cycle pass-through, so a full FIFO drops ready even in a cycle where it is popped.
  - lane_valid with lane_ready low is ignored. The upstream lane must hold its data.
- Output register: a single stage holding valid_data_out, r, g, b, last_x and sof.
  - While valid_data_out && !ready_external, all output fields are held stable.
- Pop: fifo[lane_sel] is popped when it is non-empty and (!valid_data_out || ready_external).
  - The popped pixel is loaded into the output register together with last_x = (x == W-1) and sof = (x == 0 && y == 0).
  - After the pop: lane_sel advances by 1 modulo N_LANES; x increments; on x == W-1, x wraps to 0 and y increments.
  - If the register empties (accept with no pop), valid_data_out drops to 0.
- Pixel order: other lanes never bypass lane_sel. A lane with an empty FIFO stalls the whole stream, while the remaining lanes keep filling.
- Latency: a push in cycle t into an empty pipe, with the correct lane_sel, gives valid_data_out = 1 in cycle t+2. Sustained throughput is 1 pixel/cycle.
- FSM:
  - IDLE: x = y = lane_sel = 0. On the first pop, latch W = image_width and H = image_height, then go to STREAM.
    - If image_width == 0 or image_height == 0, stay in IDLE and pop nothing.
  - STREAM: pop as above. When the pixel at (W-1, H-1) is popped, reset x, y and lane_sel to 0 and go to DRAIN.
  - DRAIN: no pops. When that pixel is accepted (valid_data_out && ready_external), pulse frame_done for one cycle and go to IDLE.
  - The next frame's dimensions are latched at its first pop. Changing image_width/image_height mid-frame has no effect on the current frame.
- Frame boundary: lane_sel restarts at 0 each frame regardless of whether W*H is a multiple of N_LANES. Upstream lanes must restart lane indexing per frame to match.
- Widths: x and y are DIM_W bits. The maximum frame is (2^DIM_W - 1)^2 pixels.

Test Plan:
- N_LANES=4, W=8, H=2, all lanes fed continuously with pixel index k as colour (r=k), ready_external=1:
  - Output is r = 0..15 in order, one per cycle, with no gaps after the first valid.
  - last_x is high at r=7 and r=15; sof is high only at r=0.
  - frame_done pulses exactly once, the cycle after r=15 is accepted.
- Same stimulus with ready_external toggled 1,0,0,1 repeatedly:
  - Output fields are stable while ready_external is low; the sequence is still 0..15 with no duplicates or losses.
  - Each lane's lane_ready drops after FIFO_DEPTH=4 unaccepted pushes.
- Lane 2 withheld for 20 cycles while lanes 0, 1 and 3 stream:
  - Output stalls after pixel 1.
  - lane_ready[0], lane_ready[1] and lane_ready[3] go low once their 4-entry FIFOs are full.
  - After lane 2 is released, order resumes at pixel 2 with no reorder.
- W=5, H=3 (15 pixels, not a multiple of 4), two back-to-back frames:
  - The second frame's first pixel comes from lane 0 with sof=1.
  - last_x is high at x=4 in each line; frame_done pulses twice.
- Assert reset_n low for one cycle mid-frame, after 6 pixels have been output:
  - Next cycle: valid_data_out=0, lane_ready all-ones, no frame_done.
  - A new frame then starts at lane 0 with sof=1 on its first pixel.
- image_width=0, with lanes pushing:
  - No output and no frame_done; FSM stays in IDLE.
  - FIFOs fill to 4 entries per lane and lane_ready goes low.
